// File: rtl/producer_data_packer.sv
// producer_data_packer
//   Packs ELEM_WIDTH accelerator elements into OUT_WIDTH words for the
//   producer_data slave port. The first element accepted into a word lands
//   in the least significant slice. A level flush request forces out a
//   partially filled word. flush_done_o confirms that nothing is left
//   in the accumulator or in the output register.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  element handshake from the accelerator
//   in_data         element payload
//   flush_i         flush request; held until flush_done_o is seen
//   flush_done_o    accumulator empty and output register drained (combinational)
//   out_valid/ready packed word handshake to producer_data
//   out_data        packed word; unused upper slices of a partial word are zero
//   out_num_elems   number of valid elements in out_data
//   elem_count_o    running count of elements handed downstream, wraps
module producer_data_packer #(
  parameter int ELEM_WIDTH = 32,
  parameter int OUT_WIDTH  = 64,
  parameter int CNT_WIDTH  = 32,
  localparam int N  = OUT_WIDTH / ELEM_WIDTH,
  localparam int NW = $clog2(N) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_WIDTH-1:0] in_data,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [NW-1:0]         out_num_elems,
  output logic [CNT_WIDTH-1:0]  elem_count_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [CW-1:0]        acc_cnt;
  logic [OUT_WIDTH-1:0] acc_ins;
  logic                 out_free;
  logic                 accept;
  logic                 full_load;
  logic                 flush_load;
  logic                 load;
  logic [OUT_WIDTH-1:0] load_data;
  logic [NW-1:0]        load_num;

  // The output register can take a new word when it is empty or when its
  // current word is being consumed in this same cycle.
  assign out_free     = !out_valid || out_ready;
  assign in_ready     = !flush_i && ((acc_cnt != LAST) || out_free);
  assign accept       = in_valid && in_ready;
  assign full_load    = accept && (acc_cnt == LAST);
  // in_ready is low during a flush, so the two load sources never coincide.
  assign flush_load   = flush_i && (acc_cnt != '0) && out_free;
  assign load         = full_load || flush_load;
  assign flush_done_o = flush_i && (acc_cnt == '0) && !out_valid;

  // Accumulator with the incoming element placed in slice acc_cnt.
  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < N; k++) begin
      if (acc_cnt == CW'(k)) acc_ins[k*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
    end
  end

  // The accumulator is cleared after every word and filled in order, so
  // the slices above acc_cnt are already zero for a partial flush.
  assign load_data = full_load ? acc_ins : acc;
  assign load_num  = full_load ? NW'(N) : NW'(acc_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (load) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      acc     <= acc_ins;
      acc_cnt <= acc_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_num_elems <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_data      <= load_data;
      out_num_elems <= load_num;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_count_o <= '0;
    end else if (out_valid && out_ready) begin
      elem_count_o <= elem_count_o + CNT_WIDTH'(out_num_elems);
    end
  end

endmodule

// File: tb/tb_producer_data_packer.sv
module tb_producer_data_packer;

  localparam int EW = 32;
  localparam int OW = 64;
  localparam int CNTW = 4;  // narrow counter so the wrap is reachable

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          flush_i;
  logic          flush_done_o;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_num_elems;
  logic [CNTW-1:0] elem_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  producer_data_packer #(.ELEM_WIDTH(EW), .OUT_WIDTH(OW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_num_elems(out_num_elems), .elem_count_o(elem_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_i = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_num", out_num_elems, 0);
    chk("rst_count", elem_count_o, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flush_done", flush_done_o, 0);
    step(); step();
    rst_n = 1'b1;

    // Basic two-element word
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1111_1111;
    step();
    chk("t1_no_early_valid", out_valid, 0);
    in_data = 32'h2222_2222;
    chk("t1_in_ready", in_ready, 1);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 64'h2222_2222_1111_1111);
    chk("t1_num", out_num_elems, 2);
    in_valid = 1'b0;
    step();
    chk("t1_count", elem_count_o, 2);
    chk("t1_drained", out_valid, 0);

    // Back-to-back stream of 8 elements
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + i;
      chk("t2_in_ready", in_ready, 1);
      step();
      chk("t2_valid", out_valid, (i % 2));
      if (i % 2 == 1) chk("t2_data", out_data, {32'h100 + i, 32'h100 + i - 1});
    end
    in_valid = 1'b0;
    step();
    chk("t2_count", elem_count_o, 10);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB0; step();
    in_data = 32'hB1; step();
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 64'h0000_00B1_0000_00B0);
    in_data = 32'hB2;
    chk("t3_ready_slot0", in_ready, 1);
    step();
    in_data = 32'hB3;
    chk("t3_ready_blocked", in_ready, 0);
    step();
    chk("t3_data_hold", out_data, 64'h0000_00B1_0000_00B0);
    chk("t3_num_hold", out_num_elems, 2);
    chk("t3_valid_hold", out_valid, 1);
    chk("t3_count_hold", elem_count_o, 10);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t3_ready_back", in_ready, 1);
    step();
    chk("t3_count_drain", elem_count_o, 12);
    chk("t3_valid_drain", out_valid, 0);
    in_valid = 1'b1; in_data = 32'hB3; step();
    chk("t3_acc_word", out_data, 64'h0000_00B3_0000_00B2);
    in_valid = 1'b0; step();
    chk("t3_count2", elem_count_o, 14);

    // Partial flush
    in_valid = 1'b1; in_data = 32'hAAAA_0001; step();
    in_valid = 1'b0; flush_i = 1'b1;
    #1;
    chk("t4_in_ready_flush", in_ready, 0);
    chk("t4_done_early", flush_done_o, 0);
    step();
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 64'h0000_0000_AAAA_0001);
    chk("t4_num", out_num_elems, 1);
    chk("t4_done_pending", flush_done_o, 0);
    step();
    chk("t4_count", elem_count_o, 15);
    chk("t4_done", flush_done_o, 1);
    chk("t4_in_ready_held", in_ready, 0);
    step();
    chk("t4_done_held", flush_done_o, 1);
    flush_i = 1'b0;
    #1;
    chk("t4_done_release", flush_done_o, 0);

    // Flush on an empty packer
    flush_i = 1'b1;
    #1;
    chk("t5_done_same_cycle", flush_done_o, 1);
    step();
    chk("t5_no_valid", out_valid, 0);
    flush_i = 1'b0;

    // Flush rising with in_valid: that element is dropped
    in_valid = 1'b1; in_data = 32'hC0; step();
    in_data = 32'hC1; flush_i = 1'b1;
    #1;
    chk("t6_in_ready", in_ready, 0);
    step();
    chk("t6_data", out_data, 64'h0000_0000_0000_00C0);
    chk("t6_num", out_num_elems, 1);
    in_valid = 1'b0;
    step();
    chk("t6_count_wrap", elem_count_o, 0);  // 15 + 1 wraps a 4-bit counter
    chk("t6_done", flush_done_o, 1);
    flush_i = 1'b0;

    // Reset mid-word with a held output word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD0; step();
    in_data = 32'hD1; step();
    in_data = 32'hD2; step();
    in_valid = 1'b0;
    chk("t7_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_valid_cleared", out_valid, 0);
    chk("t7_data_cleared", out_data, 0);
    chk("t7_count_cleared", elem_count_o, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hE0; step();
    chk("t7_no_stale_word", out_valid, 0);
    in_data = 32'hE1; step();
    in_valid = 1'b0;
    chk("t7_valid", out_valid, 1);
    chk("t7_data", out_data, 64'h0000_00E1_0000_00E0);
    chk("t7_num", out_num_elems, 2);
    step();
    chk("t7_count", elem_count_o, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
